// File: rtl/c157x_track_ctl.sv
// c157x_track_ctl: stepper decode, track-0 sense and settle/track-load handshake
module c157x_track_ctl #(
    parameter int MAX_HTRACK   = 83,
    parameter int INIT_HTRACK  = 36,
    parameter int SETTLE_TICKS = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] stp,
    input  logic       mtr,
    input  logic       disk_change,
    output logic [6:0] htrack,
    output logic       tr00_sense,
    output logic       busy,
    output logic       track_req,
    output logic [6:0] track_num,
    input  logic       track_ack
);
    localparam int CW = $clog2(SETTLE_TICKS + 1);
    localparam logic [6:0] MAX_H = 7'(MAX_HTRACK);
    localparam logic [6:0] INIT_H = 7'(INIT_HTRACK);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_TICKS - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, REQ} state_t;

    state_t        state_q, state_d;
    logic [1:0]    prev_q;
    logic          armed_q;
    logic [6:0]    htrack_q, htrack_d;
    logic          tr00_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          force_q, force_d;
    logic [6:0]    num_q, num_d;
    logic [6:0]    loaded_q, loaded_d;
    logic          step_in, step_out, step_ev;

    // prev is only trusted once it has sampled stp after reset release
    assign step_in  = armed_q && stp == prev_q + 2'd1;
    assign step_out = armed_q && stp == prev_q - 2'd1;
    assign step_ev  = mtr && (step_in || step_out);

    // head position moves one half-track per phase step, saturating at both ends
    always_comb begin
        htrack_d = !mtr ? htrack_q :
                   step_in ? (htrack_q == MAX_H ? htrack_q : htrack_q + 7'd1) :
                   step_out ? (htrack_q == 7'd0 ? htrack_q : htrack_q - 7'd1) : htrack_q;
    end

    // settle timer and load handshake; ack comparison uses the post-step position
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        force_d  = force_q | disk_change;
        num_d    = num_q;
        loaded_d = loaded_q;
        case (state_q)
            IDLE: begin
                if (step_ev || disk_change) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (step_ev || disk_change) begin
                    cnt_d = '0;
                end else if (ce) begin
                    if (cnt_q == LAST) begin
                        if (htrack_q != loaded_q || force_q) begin
                            state_d = REQ;
                            num_d   = htrack_q;
                            force_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            REQ: begin
                if (track_ack) begin
                    loaded_d = num_q;
                    if (htrack_d != num_q || force_d) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset abandons any outstanding request at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_q   <= 2'd0;
            armed_q  <= 1'b0;
            htrack_q <= INIT_H;
            tr00_q   <= INIT_H == 7'd0;
            cnt_q    <= '0;
            force_q  <= 1'b0;
            num_q    <= INIT_H;
            loaded_q <= INIT_H;
        end else begin
            state_q  <= state_d;
            prev_q   <= stp;
            armed_q  <= 1'b1;
            htrack_q <= htrack_d;
            tr00_q   <= htrack_d == 7'd0;
            cnt_q    <= cnt_d;
            force_q  <= force_d;
            num_q    <= num_d;
            loaded_q <= loaded_d;
        end
    end

    assign htrack     = htrack_q;
    assign tr00_sense = tr00_q;
    assign busy       = state_q != IDLE;
    assign track_req  = state_q == REQ;
    assign track_num  = num_q;
endmodule
